fifo_write_arbiter: RTL and testbench

FIFO_WRITE_ARBITER -- requirements
Module: fifo_write_arbiter

---
 rtl/fifo_write_arbiter.sv | 155 +++++++++++++++
 tb/tb_fifo_write_arbiter.sv | 242 ++++++++++++++++++++++++
 2 files changed

// File: rtl/fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// fifo_write_arbiter
//
// Shares the single write port of an asynchronous FIFO between NUM_REQ
// requesters. Grants are round-robin and last at most MAX_BURST beats, or
// until the owner marks its last beat. On release the next owner is chosen
// in the same cycle, so consecutive bursts have no idle cycle between them.
//
// Parameters
//   NUM_REQ    number of requesters
//   DATA_W     FIFO data width
//   MAX_BURST  maximum beats per grant (1..16)
//
// Ports
//   clk_tx      write-domain clock
//   rst_tx      asynchronous, active-high reset
//   req_valid   per-requester beat valid
//   req_data    requester i data at [i*DATA_W +: DATA_W]
//   req_last    per-requester final-beat marker
//   req_ready   per-requester beat accept (valid & ready = beat taken)
//   fifo_full   FIFO full flag
//   fifo_push   FIFO push strobe
//   fifo_wdata  FIFO write data (owner's slice)
//   grant       one-hot current owner, all-zero when idle
//   busy        high while a grant is held
// ---------------------------------------------------------------------------
module fifo_write_arbiter #(
   parameter int NUM_REQ   = 4,
   parameter int DATA_W    = 8,
   parameter int MAX_BURST = 4
) (
   input  logic                      clk_tx,
   input  logic                      rst_tx,
   input  logic [NUM_REQ-1:0]        req_valid,
   input  logic [NUM_REQ*DATA_W-1:0] req_data,
   input  logic [NUM_REQ-1:0]        req_last,
   output logic [NUM_REQ-1:0]        req_ready,
   input  logic                      fifo_full,
   output logic                      fifo_push,
   output logic [DATA_W-1:0]         fifo_wdata,
   output logic [NUM_REQ-1:0]        grant,
   output logic                      busy
);

   localparam int IDX_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

   typedef enum logic {
      IDLE  = 1'b0,
      GRANT = 1'b1
   } state_t;

   state_t           state, state_nxt;
   logic [IDX_W-1:0] owner, owner_nxt;
   logic [IDX_W-1:0] last_owner, last_owner_nxt;
   logic [3:0]       beat_cnt, beat_nxt;

   logic [IDX_W-1:0] arb_base;
   logic [IDX_W-1:0] arb_cand;
   logic [IDX_W-1:0] winner;
   logic             arb_found;
   logic             any_valid;
   logic             release_grant;

   assign any_valid = |req_valid;

   // Output decode: everything below is a function of the registered state
   // and owner, so grant/busy change only on clock edges or reset.
   // NOTE: every signal written in an always_comb gets a default on entry;
   // a path that skips an assignment would otherwise infer a latch.
   always_comb begin
      req_ready = '0;
      fifo_push = 1'b0;
      grant     = '0;
      if (state == GRANT) begin
         req_ready[owner] = ~fifo_full;
         fifo_push        = req_valid[owner] & ~fifo_full;
         grant[owner]     = 1'b1;
      end
   end

   assign busy       = (state == GRANT);
   assign fifo_wdata = req_data[int'(owner)*DATA_W +: DATA_W];

   // A burst ends on the beat that carries req_last or fills the budget.
   assign release_grant = fifo_push &
                          (req_last[owner] | (beat_cnt == 4'(MAX_BURST - 1)));

   // Round-robin search. From IDLE it starts after last_owner; on release it
   // starts after the current owner (which becomes last_owner this cycle).
   always_comb begin
      arb_base  = (state == IDLE) ? last_owner : owner;
      arb_cand  = '0;
      winner    = '0;
      arb_found = 1'b0;
      for (int k = 0; k < NUM_REQ; k++) begin
         arb_cand = IDX_W'((int'(arb_base) + 1 + k) % NUM_REQ);
         if (!arb_found && req_valid[arb_cand]) begin
            winner    = arb_cand;
            arb_found = 1'b1;
         end
      end
   end

   always_comb begin
      state_nxt      = state;
      owner_nxt      = owner;
      last_owner_nxt = last_owner;
      beat_nxt       = beat_cnt;
      case (state)
         IDLE: begin
            if (any_valid) begin
               state_nxt = GRANT;
               owner_nxt = winner;
               beat_nxt  = '0;
            end
         end
         GRANT: begin
            // A stalled or silent owner keeps its grant: nothing moves
            // unless a beat is actually pushed.
            if (fifo_push) begin
               beat_nxt = beat_cnt + 4'd1;
               if (release_grant) begin
                  last_owner_nxt = owner;
                  beat_nxt       = '0;
                  if (any_valid) begin
                     owner_nxt = winner;
                  end else begin
                     state_nxt = IDLE;
                  end
               end
            end
         end
         default: state_nxt = IDLE;
      endcase
   end

   // last_owner resets to the top index so the first search after reset
   // begins at requester 0.
   // NOTE: sequential state uses non-blocking assignments so every register
   // samples pre-edge values, independent of statement order.
   always_ff @(posedge clk_tx or posedge rst_tx) begin
      if (rst_tx) begin
         state      <= IDLE;
         owner      <= '0;
         last_owner <= IDX_W'(NUM_REQ - 1);
         beat_cnt   <= '0;
      end else begin
         state      <= state_nxt;
         owner      <= owner_nxt;
         last_owner <= last_owner_nxt;
         beat_cnt   <= beat_nxt;
      end
   end

endmodule

// File: tb/tb_fifo_write_arbiter.sv
// ---------------------------------------------------------------------------
// tb_fifo_write_arbiter
//
// Directed bench for fifo_write_arbiter. Two instances share all inputs:
// u_dut4 uses MAX_BURST=4, u_dut1 uses MAX_BURST=1. Inputs change 1 ns after
// the rising edge; outputs are compared 2 ns after the rising edge.
// ---------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_fifo_write_arbiter;

   localparam int NUM_REQ = 4;
   localparam int DATA_W  = 8;

   logic                      clk_tx;
   logic                      rst_tx;
   logic [NUM_REQ-1:0]        req_valid;
   logic [NUM_REQ*DATA_W-1:0] req_data;
   logic [NUM_REQ-1:0]        req_last;
   logic                      fifo_full;

   logic [NUM_REQ-1:0] ready4, grant4, ready1, grant1;
   logic               push4, busy4, push1, busy1;
   logic [DATA_W-1:0]  wdata4, wdata1;

   int n_checks = 0;
   int n_fail   = 0;

   fifo_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(4)) u_dut4 (
      .clk_tx     (clk_tx),
      .rst_tx     (rst_tx),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (ready4),
      .fifo_full  (fifo_full),
      .fifo_push  (push4),
      .fifo_wdata (wdata4),
      .grant      (grant4),
      .busy       (busy4)
   );

   fifo_write_arbiter #(.NUM_REQ(NUM_REQ), .DATA_W(DATA_W), .MAX_BURST(1)) u_dut1 (
      .clk_tx     (clk_tx),
      .rst_tx     (rst_tx),
      .req_valid  (req_valid),
      .req_data   (req_data),
      .req_last   (req_last),
      .req_ready  (ready1),
      .fifo_full  (fifo_full),
      .fifo_push  (push1),
      .fifo_wdata (wdata1),
      .grant      (grant1),
      .busy       (busy1)
   );

   initial begin
      clk_tx = 1'b0;
      forever #5 clk_tx = ~clk_tx;
   end

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Advance to 1 ns after the next rising edge (input-drive point).
   task automatic tick();
      @(posedge clk_tx);
      #1;
   endtask

   // Expect an active beat from requester r on the MAX_BURST=4 instance.
   task automatic expect_beat4(input string tag, input int r);
      logic [NUM_REQ-1:0] oh;
      oh = '0;
      oh[r] = 1'b1;
      #1;
      check({tag, " grant"}, 32'(grant4), 32'(oh));
      check({tag, " push"},  32'(push4),  32'd1);
      check({tag, " ready"}, 32'(ready4), 32'(oh));
      check({tag, " wdata"}, 32'(wdata4), 32'(8'hA0 | 8'(r)));
   endtask

   // Expect the idle-state outputs on the MAX_BURST=4 instance.
   task automatic expect_idle4(input string tag);
      #1;
      check({tag, " busy"},  32'(busy4),  32'd0);
      check({tag, " grant"}, 32'(grant4), 32'd0);
      check({tag, " push"},  32'(push4),  32'd0);
      check({tag, " ready"}, 32'(ready4), 32'd0);
   endtask

   // Pulse reset for one cycle with all requests quiet; returns at the
   // input-drive point of the first cycle out of reset.
   task automatic do_reset();
      req_valid = '0;
      req_last  = '0;
      fifo_full = 1'b0;
      rst_tx    = 1'b1;
      tick();
      rst_tx    = 1'b0;
   endtask

   initial begin
      rst_tx    = 1'b1;
      req_valid = 4'b1111;
      req_last  = '0;
      fifo_full = 1'b0;
      req_data  = {8'hA3, 8'hA2, 8'hA1, 8'hA0};

      // Reset holds all outputs low even with every requester valid.
      #2;
      expect_idle4("rst");
      check("rst busy1", 32'(busy1), 32'd0);
      check("rst push1", 32'(push1), 32'd0);
      tick();
      rst_tx = 1'b0;

      // Full round-robin rotation, 4 beats each, no bubble between grants.
      req_valid = 4'b1111;
      expect_idle4("rr first_cycle");
      tick();
      for (int g = 0; g < 5; g++) begin
         for (int b = 0; b < 4; b++) begin
            expect_beat4($sformatf("rr g%0d b%0d", g, b), g % 4);
            tick();
         end
      end

      // Lone requester 2 with last on its second beat.
      do_reset();
      req_valid = 4'b0100;
      expect_idle4("single first_cycle");
      tick();
      expect_beat4("single b0", 2);
      tick();
      req_last = 4'b0100;
      expect_beat4("single b1", 2);
      tick();
      // Its valid was high at release, so it is re-granted; with valid now
      // low the grant is simply held.
      req_valid = '0;
      req_last  = '0;
      #1;
      check("single after_last push",  32'(push4),  32'd0);
      check("single after_last grant", 32'(grant4), 32'b0100);
      tick();
      do_reset();
      expect_idle4("single after_reset");

      // Owner 1 stalled by fifo_full for 5 cycles mid-burst; requester 2
      // waits and takes over exactly after the 4th beat of owner 1.
      do_reset();
      req_valid = 4'b0110;
      tick();
      expect_beat4("stall b0", 1);
      tick();
      expect_beat4("stall b1", 1);
      tick();
      fifo_full = 1'b1;
      for (int c = 0; c < 5; c++) begin
         #1;
         check($sformatf("stall c%0d push", c),  32'(push4),  32'd0);
         check($sformatf("stall c%0d ready", c), 32'(ready4), 32'd0);
         check($sformatf("stall c%0d grant", c), 32'(grant4), 32'b0010);
         check($sformatf("stall c%0d busy", c),  32'(busy4),  32'd1);
         tick();
      end
      fifo_full = 1'b0;
      expect_beat4("stall b2", 1);
      tick();
      expect_beat4("stall b3", 1);
      tick();
      expect_beat4("stall next_owner", 2);
      tick();

      // Owner 0 goes silent for 3 cycles while requester 3 waits.
      do_reset();
      req_valid = 4'b1001;
      tick();
      expect_beat4("hold b0", 0);
      tick();
      req_valid = 4'b1000;
      for (int c = 0; c < 3; c++) begin
         #1;
         check($sformatf("hold c%0d grant", c), 32'(grant4), 32'b0001);
         check($sformatf("hold c%0d push", c),  32'(push4),  32'd0);
         check($sformatf("hold c%0d ready", c), 32'(ready4), 32'b0001);
         tick();
      end
      req_valid = 4'b1001;
      expect_beat4("hold b1", 0);
      tick();
      expect_beat4("hold b2", 0);
      tick();
      expect_beat4("hold b3", 0);
      tick();
      expect_beat4("hold next_owner", 3);
      tick();

      // Reset in the middle of owner 3's third beat.
      do_reset();
      req_valid = 4'b1000;
      tick();
      expect_beat4("abort b0", 3);
      tick();
      expect_beat4("abort b1", 3);
      tick();
      expect_beat4("abort b2", 3);
      rst_tx = 1'b1;
      expect_idle4("abort in_reset");
      req_valid = 4'b1001;
      tick();
      rst_tx = 1'b0;
      expect_idle4("abort released");
      tick();
      expect_beat4("abort first_owner", 0);
      tick();

      // MAX_BURST=1 instance: single beats alternating between 0 and 2.
      do_reset();
      req_valid = 4'b0101;
      tick();
      for (int c = 0; c < 4; c++) begin
         logic [NUM_REQ-1:0] oh;
         oh = (c % 2 == 0) ? 4'b0001 : 4'b0100;
         #1;
         check($sformatf("mb1 c%0d grant", c), 32'(grant1), 32'(oh));
         check($sformatf("mb1 c%0d push", c),  32'(push1),  32'd1);
         check($sformatf("mb1 c%0d wdata", c), 32'(wdata1),
               (c % 2 == 0) ? 32'hA0 : 32'hA2);
         tick();
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
